// File: rtl/jk_seq_pkg.sv
// Shared constants for the JK-cell sequencing controller: FSM state codes
// and the per-bit {J,K} excitation codes.
package jk_seq_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Per-bit excitation, packed as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low clear.
// next q = J&~q | ~K&q.
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_r;

    // JK storage: hold, set, clear or toggle on each rising edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_r <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: q_r <= q_r;
                JK_SET:  q_r <= 1'b1;
                JK_CLR:  q_r <= 1'b0;
                JK_TOG:  q_r <= ~q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q = q_r;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencing controller for an N-bit register built only from JK cells.
// The controller never writes q directly: it only computes J/K vectors
// that load, hold or count the register. A start in IDLE latches the
// direction and terminal value, RUN steps once per cycle until q reaches
// the target, DONE pulses for one cycle, then back to IDLE.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             ld,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             up,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             halt,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic             dir_r;
    logic             dir_nx_s;
    logic [WIDTH-1:0] target_r;
    logic [WIDTH-1:0] target_nx_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] tog_s;

    // Storage: one JK cell per register bit
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell u_cell (
                .clk  (clk),
                .clrn (clrn),
                .j    (j_s[g]),
                .k    (k_s[g]),
                .q    (q_s[g])
            );
        end
    endgenerate

    // Counting toggle mask: bit i toggles when all lower bits are ones
    // (up) or all zeros (down); bit 0 always toggles
    always_comb begin
        logic chain_v;
        chain_v = 1'b1;
        tog_s   = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            tog_s[i] = chain_v;
            if (dir_r) begin
                chain_v = chain_v & q_s[i];
            end else begin
                chain_v = chain_v & ~q_s[i];
            end
        end
    end

    // Next state, latched sequence parameters and J/K excitation
    always_comb begin
        state_nx_s  = state_r;
        dir_nx_s    = dir_r;
        target_nx_s = target_r;
        j_s         = {WIDTH{1'b0}};
        k_s         = {WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (ld) begin
                    // SET where load_val is 1, CLR where it is 0
                    j_s = load_val;
                    k_s = ~load_val;
                end else if (start) begin
                    state_nx_s  = ST_RUN;
                    dir_nx_s    = up;
                    target_nx_s = up ? mod_val : {WIDTH{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nx_s = ST_IDLE;
                end else if (q_s == target_r) begin
                    state_nx_s = ST_DONE;
                end else begin
                    j_s = tog_s;
                    k_s = tog_s;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, latched direction/target and registered status flags
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r  <= ST_IDLE;
            dir_r    <= 1'b1;
            target_r <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            dir_r    <= dir_nx_s;
            target_r <= target_nx_s;
            busy_r   <= (state_nx_s == ST_RUN);
            done_r   <= (state_nx_s == ST_DONE);
        end
    end

    assign q    = q_s;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Self-checking bench for jk_seq_ctrl: an arithmetic reference model is
// compared every cycle, plus hand-computed literal checkpoints.
module tb_jk_seq_ctrl;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         up = 1'b0;
    logic [W-1:0] mod_val = '0;
    logic         halt = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    // Reference model: mode 0 idle, 1 counting, 2 completion cycle
    int m_q    = 0;
    int m_mode = 0;
    int m_dir  = 1;
    int m_tgt  = 0;

    jk_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ld       (ld),
        .load_val (load_val),
        .start    (start),
        .up       (up),
        .mod_val  (mod_val),
        .halt     (halt),
        .q        (q),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model update on each edge, from the spec's rules in plain arithmetic
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_q    <= 0;
            m_mode <= 0;
            m_dir  <= 1;
            m_tgt  <= 0;
        end else begin
            case (m_mode)
                0: begin
                    if (ld) begin
                        m_q <= int'(load_val);
                    end else if (start) begin
                        m_mode <= 1;
                        m_dir  <= int'(up);
                        m_tgt  <= up ? int'(mod_val) : 0;
                    end
                end
                1: begin
                    if (halt) m_mode <= 0;
                    else if (m_q == m_tgt) m_mode <= 2;
                    else if (m_dir != 0) m_q <= (m_q + 1) & MASK;
                    else m_q <= (m_q + MASK) & MASK;
                end
                2: m_mode <= 0;
                default: m_mode <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model, plus done-pulse counting
    always @(negedge clk) begin
        chk("model_q", int'(q), m_q);
        chk("model_busy", int'(busy), (m_mode == 1) ? 1 : 0);
        chk("model_done", int'(done), (m_mode == 2) ? 1 : 0);
        if (done) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int v);
        ld = 1'b1;
        load_val = W'(v);
        step();
        ld = 1'b0;
    endtask

    task automatic go(input logic dir, input int mv);
        start = 1'b1;
        up = dir;
        mod_val = W'(mv);
        step();
        start = 1'b0;
    endtask

    int d0;
    int exp_q[6];
    int exp_b[6];
    int exp_d[6];

    initial begin
        // Reset state
        step();
        step();
        chk("reset_q", int'(q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        clrn = 1'b1;
        step();

        // Load and load-beats-start
        load(10);
        chk("load_q", int'(q), 10);
        chk("load_busy", int'(busy), 0);
        ld = 1'b1; start = 1'b1; up = 1'b1; mod_val = 4'd9; load_val = 4'd3;
        step();
        ld = 1'b0; start = 1'b0;
        chk("ldstart_q", int'(q), 3);
        chk("ldstart_busy", int'(busy), 0);
        step();
        chk("ldstart_idle", int'(busy), 0);

        // Up-count 2 -> 5: after E0..E5
        exp_q = '{2, 3, 4, 5, 5, 5};
        exp_b = '{1, 1, 1, 1, 0, 0};
        exp_d = '{0, 0, 0, 0, 1, 0};
        load(2);
        d0 = done_cnt;
        go(1'b1, 5);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("up_q_E%0d", i), int'(q), exp_q[i]);
            chk($sformatf("up_busy_E%0d", i), int'(busy), exp_b[i]);
            chk($sformatf("up_done_E%0d", i), int'(done), exp_d[i]);
            if (i < 5) step();
        end
        chk("up_done_pulses", done_cnt - d0, 1);

        // Down-count 3 -> 0
        load(3);
        d0 = done_cnt;
        go(1'b0, 9);
        step(); chk("dn_E1", int'(q), 2);
        step(); chk("dn_E2", int'(q), 1);
        step(); chk("dn_E3", int'(q), 0);
        step(); chk("dn_done", int'(done), 1);
        step();
        chk("dn_pulses", done_cnt - d0, 1);
        chk("dn_final", int'(q), 0);

        // Up-count with wrap 14 -> 15,0,1
        load(14);
        d0 = done_cnt;
        go(1'b1, 1);
        step(); chk("wrap_E1", int'(q), 15);
        step(); chk("wrap_E2", int'(q), 0);
        step(); chk("wrap_E3", int'(q), 1);
        step(); chk("wrap_done", int'(done), 1);
        step();
        chk("wrap_pulses", done_cnt - d0, 1);

        // Zero distance
        load(7);
        d0 = done_cnt;
        go(1'b1, 7);
        chk("zero_busy", int'(busy), 1);
        step();
        chk("zero_done", int'(done), 1);
        chk("zero_busy_off", int'(busy), 0);
        chk("zero_q", int'(q), 7);
        step();
        chk("zero_pulses", done_cnt - d0, 1);

        // Halt at q=4 during up-count to 9
        load(2);
        d0 = done_cnt;
        go(1'b1, 9);
        step();
        step();
        chk("halt_pre_q", int'(q), 4);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_busy", int'(busy), 0);
        chk("halt_q", int'(q), 4);
        step(); step(); step();
        chk("halt_q_hold", int'(q), 4);
        chk("halt_no_done", done_cnt - d0, 0);

        // Start pulse during RUN must not change latched target/direction
        load(0);
        d0 = done_cnt;
        go(1'b1, 3);
        step();
        start = 1'b1; up = 1'b0; mod_val = 4'd9;
        step();
        start = 1'b0;
        step();
        chk("ign_q", int'(q), 3);
        step();
        chk("ign_done", int'(done), 1);
        step(); step();
        chk("ign_pulses", done_cnt - d0, 1);
        chk("ign_final", int'(q), 3);

        // Reset mid-count at q=5
        load(0);
        d0 = done_cnt;
        go(1'b1, 9);
        for (int i = 0; i < 5; i++) step();
        chk("rst_pre_q", int'(q), 5);
        #2 clrn = 1'b0;
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        step();
        clrn = 1'b1;
        step(); step(); step();
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle_q", int'(q), 0);
        chk("rst_idle_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
